// File: rtl/note_spawn_scheduler_pkg.sv
// Shared types and constants for the note spawn scheduler: FSM states,
// the note generator position range, and the lane-mask type.
package note_spawn_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int LANE_POS_MIN = 180;
    localparam int LANE_POS_MAX = 196;
    localparam int LANE_STEP    = 4;

    // A note walks MIN..MAX inclusive, so it sees one strobe per position.
    localparam int LANE_STEPS_DEFAULT = (LANE_POS_MAX - LANE_POS_MIN) / LANE_STEP + 1;

    localparam int LANES_DEFAULT = 4;
    typedef logic [LANES_DEFAULT-1:0] lane_mask_t;

endpackage

// File: rtl/note_spawn_scheduler_pattern_rom.sv
// Beat pattern ROM: maps a beat index to the mask of lanes spawned on that
// beat, with a registered (one-cycle latency) output.
module note_pattern_rom
    import note_spawn_scheduler_pkg::*;
#(
    parameter int                            NUM_LANES = LANES_DEFAULT,
    parameter int                            SONG_LEN  = 32,
    parameter logic [SONG_LEN*NUM_LANES-1:0] PATTERN   = '0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [7:0]           addr_i,
    output logic [NUM_LANES-1:0] mask_o
);

    logic [NUM_LANES-1:0] mask_d;
    logic [NUM_LANES-1:0] mask_q;

    always_comb begin
        mask_d = '0;
        for (int b = 0; b < SONG_LEN; b++) begin
            if (addr_i == 8'(b)) begin
                mask_d = PATTERN[b*NUM_LANES +: NUM_LANES];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask_o = mask_q;

endmodule

// File: rtl/note_spawn_scheduler.sv
// Beat-paced note spawner: fetches a lane mask per beat and strobes each
// active lane on frame ticks until it retires. Optional: SONG_LOOP_EN.
module note_spawn_scheduler
    import note_spawn_scheduler_pkg::*;
#(
    parameter int                            NUM_LANES      = LANES_DEFAULT,
    parameter int                            TICKS_PER_BEAT = 8,
    parameter int                            SONG_LEN       = 32,
    parameter int                            LANE_STEPS     = LANE_STEPS_DEFAULT,
    parameter logic [SONG_LEN*NUM_LANES-1:0] PATTERN        = {SONG_LEN{NUM_LANES'(1)}}
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 tick,
    output logic [NUM_LANES-1:0] map,
    output logic [NUM_LANES-1:0] lane_active,
    output logic [7:0]           beat_idx,
    output logic                 overrun,
    output logic                 song_done
);

    localparam int         CNT_W     = $clog2(LANE_STEPS + 1);
    localparam logic [7:0] LAST_TICK = 8'(TICKS_PER_BEAT - 1);
    localparam logic [7:0] LAST_BEAT = 8'(SONG_LEN - 1);

    state_e               state_q;
    logic [7:0]           beat_q;
    logic [7:0]           beat_d;
    logic [7:0]           tick_cnt_q;
    logic                 pending_q;
    logic                 overrun_q;
    logic                 song_done_q;
    logic [NUM_LANES-1:0] rom_mask;
    logic [NUM_LANES-1:0] spawn_mask;
    logic                 start_ok;
    logic                 step_ev;
    logic                 beat_end;
    logic                 song_end;
    wire  [NUM_LANES-1:0] strobe_w;
    wire  [NUM_LANES-1:0] active_w;

    always_comb begin
        start_ok   = start && (state_q == ST_IDLE || state_q == ST_DONE);
        // A tick caught during FETCH is replayed on the first PLAY cycle.
        step_ev    = (state_q == ST_PLAY && (tick || pending_q)) ||
                     (state_q == ST_DONE && tick);
        beat_end   = (state_q == ST_PLAY) && step_ev && (tick_cnt_q == LAST_TICK);
        song_end   = beat_end && (beat_q == LAST_BEAT);
        spawn_mask = (state_q == ST_FETCH) ? rom_mask : '0;
        beat_d     = beat_q;
        if (start_ok) begin
            beat_d = '0;
        end else if (beat_end && !song_end) begin
            beat_d = beat_q + 8'd1;
        end
`ifdef SONG_LOOP_EN
        else if (song_end) begin
            beat_d = '0;
        end
`endif
    end

    // The ROM is addressed with the next beat so its mask is ready in FETCH.
    note_pattern_rom #(
        .NUM_LANES(NUM_LANES),
        .SONG_LEN (SONG_LEN),
        .PATTERN  (PATTERN)
    ) u_rom (
        .clk   (clk),
        .resetn(resetn),
        .addr_i(beat_d),
        .mask_o(rom_mask)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            tick_cnt_q  <= '0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            beat_q <= beat_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_FETCH;
                        tick_cnt_q <= '0;
                        overrun_q  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state_q   <= ST_PLAY;
                    pending_q <= tick;
                    if (|(spawn_mask & active_w)) begin
                        overrun_q <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    pending_q <= 1'b0;
                    if (beat_end) begin
                        tick_cnt_q <= '0;
                        if (song_end) begin
`ifdef SONG_LOOP_EN
                            state_q <= ST_FETCH;
`else
                            state_q     <= ST_DONE;
                            song_done_q <= 1'b1;
`endif
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end else if (step_ev) begin
                        tick_cnt_q <= tick_cnt_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_FETCH;
                        tick_cnt_q  <= '0;
                        overrun_q   <= 1'b0;
                        song_done_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [CNT_W-1:0] step_cnt_q;
        logic             active_q;
        logic             strobe_q;

        // The strobe that reaches LANE_STEPS is still issued; it also retires the lane.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                step_cnt_q <= '0;
                active_q   <= 1'b0;
                strobe_q   <= 1'b0;
            end else begin
                strobe_q <= 1'b0;
                if (spawn_mask[i]) begin
                    active_q   <= 1'b1;
                    step_cnt_q <= '0;
                end else if (step_ev && active_q) begin
                    strobe_q   <= 1'b1;
                    step_cnt_q <= step_cnt_q + CNT_W'(1);
                    if (step_cnt_q == CNT_W'(LANE_STEPS - 1)) begin
                        active_q <= 1'b0;
                    end
                end
            end
        end

        assign strobe_w[i] = strobe_q;
        assign active_w[i] = active_q;
    end

    assign map         = strobe_w;
    assign lane_active = active_w;
    assign beat_idx    = beat_q;
    assign overrun     = overrun_q;
    assign song_done   = song_done_q;

endmodule

// File: tb/tb_note_spawn_scheduler.sv
// Self-checking bench for note_spawn_scheduler: two instances (long song with
// a single lane-0 note, and a two-beat song spawning all lanes every beat).
module tb_note_spawn_scheduler;
    import note_spawn_scheduler_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic start_a = 1'b0, tick_a = 1'b0;
    logic start_b = 1'b0, tick_b = 1'b0;
    lane_mask_t map_a, active_a, map_b, active_b;
    logic [7:0] beat_a, beat_b;
    logic overrun_a, overrun_b, song_done_a, song_done_b;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        lane_mask_t map;
        lane_mask_t act;
        logic       ovr;
        logic       done;
        logic [7:0] beat;
    } exp_t;

    typedef struct packed {
        logic st;
        logic tk;
        exp_t e;
    } row_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    note_spawn_scheduler #(
        .NUM_LANES(4), .TICKS_PER_BEAT(8), .SONG_LEN(32), .LANE_STEPS(5),
        .PATTERN(128'h1)
    ) dut_a (
        .clk(clk), .resetn(resetn), .start(start_a), .tick(tick_a),
        .map(map_a), .lane_active(active_a), .beat_idx(beat_a),
        .overrun(overrun_a), .song_done(song_done_a)
    );

    note_spawn_scheduler #(
        .NUM_LANES(4), .TICKS_PER_BEAT(2), .SONG_LEN(2), .LANE_STEPS(5),
        .PATTERN(8'hFF)
    ) dut_b (
        .clk(clk), .resetn(resetn), .start(start_b), .tick(tick_b),
        .map(map_b), .lane_active(active_b), .beat_idx(beat_b),
        .overrun(overrun_b), .song_done(song_done_b)
    );

    function automatic row_t mk(input logic st, input logic tk, input lane_mask_t m,
                                input lane_mask_t a, input logic o, input logic d,
                                input logic [7:0] b);
        row_t r;
        r.st = st; r.tk = tk;
        r.e.map = m; r.e.act = a; r.e.ovr = o; r.e.done = d; r.e.beat = b;
        return r;
    endfunction

    task automatic edge_a(input logic st, input logic tk);
        start_a = st; tick_a = tk;
        @(posedge clk); #1;
        start_a = 1'b0; tick_a = 1'b0;
    endtask

    task automatic edge_b(input logic st, input logic tk);
        start_b = st; tick_b = tk;
        @(posedge clk); #1;
        start_b = 1'b0; tick_b = 1'b0;
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({map_a, active_a, beat_a, overrun_a, song_done_a} !== 18'd0) begin
            failures++;
            $display("FAIL reset_a got map=%b act=%b beat=%0d ovr=%b done=%b required all 0",
                     map_a, active_a, beat_a, overrun_a, song_done_a);
        end
        checks++;
        if ({map_b, active_b, beat_b, overrun_b, song_done_b} !== 18'd0) begin
            failures++;
            $display("FAIL reset_b got map=%b act=%b beat=%0d ovr=%b done=%b required all 0",
                     map_b, active_b, beat_b, overrun_b, song_done_b);
        end
        resetn = 1'b1;
        edge_a(1'b0, 1'b1);
        edge_b(1'b0, 1'b1);
        checks++;
        if ({map_a, active_a, map_b, active_b} !== 16'd0) begin
            failures++;
            $display("FAIL idle_tick got map_a=%b act_a=%b map_b=%b act_b=%b required 0",
                     map_a, active_a, map_b, active_b);
        end
    endtask

    // Lane 0 spawned on beat 0: five strobes, retired with the fifth, beat 1 after 8 ticks.
    task automatic test_single_lane();
        row_t rows[$];
        exp_t e, got;
        rows.push_back(mk(1, 0, 4'b0000, 4'b0000, 0, 0, 8'd0));
        rows.push_back(mk(0, 0, 4'b0000, 4'b0001, 0, 0, 8'd0));
        for (int k = 1; k <= 8; k++) begin
            rows.push_back(mk(0, 1, (k <= 5) ? 4'b0001 : 4'b0000, (k < 5) ? 4'b0001 : 4'b0000,
                              0, 0, (k == 8) ? 8'd1 : 8'd0));
            rows.push_back(mk(0, 0, 4'b0000, (k < 5) ? 4'b0001 : 4'b0000,
                              0, 0, (k == 8) ? 8'd1 : 8'd0));
        end
        foreach (rows[n]) begin
            sb.push_back(rows[n].e);
            edge_a(rows[n].st, rows[n].tk);
            e = sb.pop_front();
            got = {map_a, active_a, overrun_a, song_done_a, beat_a};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL single_lane[%0d] got map=%b act=%b ovr=%b done=%b beat=%0d required map=%b act=%b ovr=%b done=%b beat=%0d",
                         n, got.map, got.act, got.ovr, got.done, got.beat,
                         e.map, e.act, e.ovr, e.done, e.beat);
            end
        end
    endtask

    // Overrun on beat 1, song end with lanes still strobing, restart, and FETCH-cycle ticks.
    task automatic test_overrun_done_pending();
        row_t rows[$];
        exp_t e, got;
        rows = '{
            mk(1, 0, 4'h0, 4'h0, 0, 0, 8'd0), mk(0, 0, 4'h0, 4'hF, 0, 0, 8'd0),
            mk(0, 1, 4'hF, 4'hF, 0, 0, 8'd0), mk(0, 1, 4'hF, 4'hF, 0, 0, 8'd1),
            mk(0, 0, 4'h0, 4'hF, 1, 0, 8'd1), mk(0, 1, 4'hF, 4'hF, 1, 0, 8'd1),
            mk(0, 1, 4'hF, 4'hF, 1, 1, 8'd1), mk(0, 0, 4'h0, 4'hF, 1, 1, 8'd1),
            mk(0, 1, 4'hF, 4'hF, 1, 1, 8'd1), mk(0, 1, 4'hF, 4'hF, 1, 1, 8'd1),
            mk(0, 1, 4'hF, 4'h0, 1, 1, 8'd1), mk(0, 1, 4'h0, 4'h0, 1, 1, 8'd1),
            mk(1, 0, 4'h0, 4'h0, 0, 0, 8'd0), mk(0, 1, 4'h0, 4'hF, 0, 0, 8'd0),
            mk(0, 0, 4'hF, 4'hF, 0, 0, 8'd0), mk(0, 0, 4'h0, 4'hF, 0, 0, 8'd0),
            mk(0, 1, 4'hF, 4'hF, 0, 0, 8'd1), mk(0, 1, 4'h0, 4'hF, 1, 0, 8'd1),
            mk(0, 1, 4'hF, 4'hF, 1, 0, 8'd1), mk(0, 0, 4'h0, 4'hF, 1, 0, 8'd1),
            mk(0, 1, 4'hF, 4'hF, 1, 1, 8'd1), mk(0, 1, 4'hF, 4'hF, 1, 1, 8'd1),
            mk(0, 1, 4'hF, 4'hF, 1, 1, 8'd1), mk(0, 1, 4'hF, 4'h0, 1, 1, 8'd1),
            mk(0, 1, 4'h0, 4'h0, 1, 1, 8'd1)
        };
        foreach (rows[n]) begin
            sb.push_back(rows[n].e);
            edge_b(rows[n].st, rows[n].tk);
            e = sb.pop_front();
            got = {map_b, active_b, overrun_b, song_done_b, beat_b};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL overrun_done_pending[%0d] got map=%b act=%b ovr=%b done=%b beat=%0d required map=%b act=%b ovr=%b done=%b beat=%0d",
                         n, got.map, got.act, got.ovr, got.done, got.beat,
                         e.map, e.act, e.ovr, e.done, e.beat);
            end
        end
    endtask

    // Start pulses in FETCH and PLAY must not restart the song.
    task automatic test_start_ignored();
        row_t rows[$];
        exp_t e, got;
        rows = '{
            mk(1, 0, 4'h0, 4'h0, 0, 0, 8'd0), mk(1, 0, 4'h0, 4'hF, 0, 0, 8'd0),
            mk(0, 1, 4'hF, 4'hF, 0, 0, 8'd0), mk(1, 0, 4'h0, 4'hF, 0, 0, 8'd0),
            mk(0, 1, 4'hF, 4'hF, 0, 0, 8'd1), mk(0, 0, 4'h0, 4'hF, 1, 0, 8'd1),
            mk(0, 1, 4'hF, 4'hF, 1, 0, 8'd1)
        };
        foreach (rows[n]) begin
            sb.push_back(rows[n].e);
            edge_b(rows[n].st, rows[n].tk);
            e = sb.pop_front();
            got = {map_b, active_b, overrun_b, song_done_b, beat_b};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL start_ignored[%0d] got map=%b act=%b ovr=%b done=%b beat=%0d required map=%b act=%b ovr=%b done=%b beat=%0d",
                         n, got.map, got.act, got.ovr, got.done, got.beat,
                         e.map, e.act, e.ovr, e.done, e.beat);
            end
        end
    endtask

    // Dut B is mid-PLAY with strobes out; reset must clear everything at once.
    task automatic test_reset_mid_play();
        resetn = 1'b0;
        #1;
        checks++;
        if ({map_b, active_b, beat_b, overrun_b, song_done_b} !== 18'd0) begin
            failures++;
            $display("FAIL reset_mid_play got map=%b act=%b beat=%0d ovr=%b done=%b required all 0",
                     map_b, active_b, beat_b, overrun_b, song_done_b);
        end
        tick_b = 1'b1;
        @(posedge clk); #1;
        tick_b = 1'b0;
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            edge_b(1'b0, 1'b1);
            checks++;
            if ({map_b, active_b} !== 8'd0) begin
                failures++;
                $display("FAIL after_reset[%0d] got map=%b act=%b required map=0000 act=0000",
                         k, map_b, active_b);
            end
        end
    endtask

    // Looping build: the two-beat song wraps to beat 0 and never finishes.
    task automatic test_song_loop();
        logic [7:0] beat_sb[$];
        logic [7:0] want;
        edge_b(1'b1, 1'b0);
        edge_b(1'b0, 1'b0);
        checks++;
        if (beat_b !== 8'd0) begin
            failures++;
            $display("FAIL loop_first_beat got %0d required 0", beat_b);
        end
        for (int k = 0; k < 4; k++) begin
            beat_sb.push_back((k % 2 == 0) ? 8'd1 : 8'd0);
            edge_b(1'b0, 1'b1);
            edge_b(1'b0, 1'b1);
            want = beat_sb.pop_front();
            checks++;
            if (beat_b !== want || song_done_b !== 1'b0) begin
                failures++;
                $display("FAIL loop_beat[%0d] got beat=%0d done=%b required beat=%0d done=0",
                         k, beat_b, song_done_b, want);
            end
            edge_b(1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single_lane();
`ifdef SONG_LOOP_EN
        test_song_loop();
`else
        test_overrun_done_pending();
        test_start_ignored();
        test_reset_mid_play();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "bench did not complete");
    end

endmodule
